// File: rtl/id_pkg.sv
// Shared decode types for the instruction-decode stage: opcodes, control bundle,
// stage FSM states and the opcode-to-control decode function.
package id_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_INC, OP_SRA, OP_SRL, OP_SLL,
        OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_CALL, OP_RET, OP_HLT
    } opcd_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       call;
        logic       ret;
        logic       pc_to_mem;
        logic       sp_addr;
    } ctrl_t;

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALT} state_t;

    // re0/re1 mark which read ports the opcode actually consumes (load-use hazard).
    typedef struct packed {
        ctrl_t ctrl;
        logic  re0;
        logic  re1;
    } dec_t;

    function automatic dec_t decode(input opcd_t op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
                d.ctrl.alu_op = 4'(op); d.ctrl.reg_write = 1'b1;
                d.re0 = 1'b1; d.re1 = 1'b1;
            end
            OP_INC, OP_SRA, OP_SRL, OP_SLL: begin
                d.ctrl.alu_op = 4'(op); d.ctrl.alu_src = 1'b1;
                d.ctrl.reg_write = 1'b1; d.re0 = 1'b1;
            end
            OP_LW: begin
                d.ctrl.alu_src = 1'b1; d.ctrl.reg_write = 1'b1; d.ctrl.mem_read = 1'b1;
                d.ctrl.mem_to_reg = 1'b1; d.ctrl.sp_addr = 1'b1; d.re0 = 1'b1;
            end
            OP_SW: begin
                d.ctrl.alu_src = 1'b1; d.ctrl.mem_write = 1'b1; d.ctrl.sp_addr = 1'b1;
                d.re0 = 1'b1; d.re1 = 1'b1;
            end
            OP_LHB, OP_LLB: begin
                d.ctrl.alu_op = 4'(op); d.ctrl.alu_src = 1'b1;
                d.ctrl.reg_write = 1'b1; d.re0 = 1'b1;
            end
            OP_B:    d.ctrl.branch = 1'b1;
            OP_CALL: begin
                d.ctrl.call = 1'b1; d.ctrl.reg_write = 1'b1; d.ctrl.pc_to_mem = 1'b1;
            end
            OP_RET:  begin d.ctrl.ret = 1'b1; d.re0 = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read / one-write register file with write-to-read bypass and async clear.
module id_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr0,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic [NREG-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    regs <= '0;
        else if (we) regs[waddr] <= wdata;
    end

    assign rdata0 = (we && waddr == raddr0) ? wdata : regs[raddr0];
    assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];

endmodule

// File: rtl/id_stage_p.sv
// Instruction-decode pipeline stage: one-entry stage register, combinational
// decode, register read with bypass, load-use stall and sticky halt.
module id_stage_p import id_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int SP_REG = 14,
    parameter int LR_REG = 15,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc_inc,
    output logic              if_ready,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc_inc,
    output logic [DATA_W-1:0] r0data,
    output logic [DATA_W-1:0] r1data,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] offset,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [2:0]        bcond,
    output logic [REG_AW-1:0] id_dst,
    output ctrl_t             ctrl,
    output logic [DATA_W-1:0] pc_call,
    output logic              halted
);

    localparam logic [REG_AW-1:0] SP = REG_AW'(SP_REG);
    localparam logic [REG_AW-1:0] LR = REG_AW'(LR_REG);

    logic              valid;
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc_inc;
    state_t            state, state_nx;
    opcd_t             op;
    dec_t              dec;
    logic [REG_AW-1:0] ra0, ra1;
    logic              live, hazard, load;

    assign op    = opcd_t'(instr[15:12]);
    assign dec   = decode(op);
    assign rd    = REG_AW'(instr[11:8]);
    assign rs    = REG_AW'(instr[7:4]);
    assign rt    = REG_AW'(instr[3:0]);
    assign bcond = instr[11:9];

    always_comb begin
        case (op)
            OP_LHB, OP_LLB:  ra0 = rd;
            OP_LW, OP_SW:    ra0 = SP;
            OP_CALL, OP_RET: ra0 = LR;
            default:         ra0 = rs;
        endcase
    end

    assign ra1    = (op inside {OP_SW, OP_LHB, OP_LLB}) ? rd : rt;
    assign id_dst = (op inside {OP_CALL, OP_RET}) ? LR : rd;

    // A halted stage never presents its register, so it can never stall either.
    assign live     = valid && (state != ST_HALT);
    assign hazard   = live && ex_memread &&
                      ((dec.re0 && ex_dst == ra0) || (dec.re1 && ex_dst == ra1));
    assign id_valid = live && !hazard;
    assign if_ready = (state == ST_RUN) && (!id_valid || ex_ready) && !hazard;
    assign load     = if_valid && if_ready;
    assign halted   = (state == ST_HALT);

    assign ctrl      = id_valid ? dec.ctrl : '0;
    assign imm       = (op inside {OP_INC, OP_SRA, OP_SRL, OP_SLL}) ?
                       DATA_W'($signed(instr[3:0])) : DATA_W'($signed(instr[7:0]));
    assign offset    = (op == OP_B) ? DATA_W'($signed(instr[8:0])) : DATA_W'($signed(instr[7:0]));
    assign id_pc_inc = pc_inc;
    assign pc_call   = {pc_inc[DATA_W-1:12], instr[11:0]};

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (!flush) begin
                    if (hazard)                                  state_nx = ST_STALL;
                    else if (valid && op == OP_HLT && ex_ready)  state_nx = ST_HALT;
                end
            end
            ST_STALL: if (flush || !hazard) state_nx = ST_RUN;
            default:  state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            valid  <= 1'b0;
            instr  <= '0;
            pc_inc <= '0;
        end else begin
            state <= state_nx;
            // The HLT is retired on halt entry; anything fetched alongside it is dropped.
            if (flush || state_nx == ST_HALT) valid <= 1'b0;
            else if (load) begin
                valid  <= 1'b1;
                instr  <= if_instr;
                pc_inc <= if_pc_inc;
            end else if (id_valid && ex_ready) valid <= 1'b0;
        end
    end

    id_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr0 (ra0),
        .raddr1 (ra1),
        .rdata0 (r0data),
        .rdata1 (r1data)
    );

endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: directed scenarios, then random traffic checked by a
// scoreboard against an ISA-level model of decode, hazards and the register file.
module tb_id_stage_p;
    import id_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic        if_valid = 0, flush = 0, ex_ready = 1, ex_memread = 0, wb_we = 0;
    logic [15:0] if_instr = 0, if_pc_inc = 0, wb_data = 0;
    logic [3:0]  ex_dst = 0, wb_addr = 0;
    logic        if_ready, id_valid, halted;
    logic [15:0] id_pc_inc, r0data, r1data, imm, offset, pc_call;
    logic [3:0]  rs, rt, rd, id_dst;
    logic [2:0]  bcond;
    ctrl_t       ctrl;

    id_stage_p dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
        .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready), .ex_memread(ex_memread),
        .ex_dst(ex_dst), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc_inc(id_pc_inc), .r0data(r0data), .r1data(r1data),
        .imm(imm), .offset(offset), .rs(rs), .rt(rt), .rd(rd), .bcond(bcond),
        .id_dst(id_dst), .ctrl(ctrl), .pc_call(pc_call), .halted(halted)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] ins, pc, imm, off, pcc;
        logic [3:0]  a0, a1, dst;
        logic        re0, re1;
        ctrl_t       c;
    } exp_t;

    exp_t        q[$];
    logic [15:0] regs [16];
    logic        sb_on = 0;

    function automatic exp_t mk_exp(input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        logic [3:0] op;
        op = ins[15:12];
        e = '0;
        e.ins = ins;
        e.pc  = pc;
        e.imm = (op >= 4 && op <= 7) ? {{12{ins[3]}}, ins[3:0]} : {{8{ins[7]}}, ins[7:0]};
        e.off = (op == 12) ? {{7{ins[8]}}, ins[8:0]} : {{8{ins[7]}}, ins[7:0]};
        e.pcc = {pc[15:12], ins[11:0]};
        e.a0  = (op == 10 || op == 11) ? ins[11:8] : (op == 8 || op == 9) ? 4'd14 :
                (op == 13 || op == 14) ? 4'd15 : ins[7:4];
        e.a1  = (op == 9 || op == 10 || op == 11) ? ins[11:8] : ins[3:0];
        e.dst = (op == 13 || op == 14) ? 4'd15 : ins[11:8];
        e.re0 = (op <= 11) || (op == 14);
        e.re1 = (op <= 3) || (op == 9);
        e.c.alu_op     = (op < 8 || op == 10 || op == 11) ? op : 4'd0;
        e.c.alu_src    = (op >= 4 && op <= 11);
        e.c.reg_write  = (op <= 8) || op == 10 || op == 11 || op == 13;
        e.c.mem_read   = (op == 8);
        e.c.mem_to_reg = (op == 8);
        e.c.mem_write  = (op == 9);
        e.c.sp_addr    = (op == 8 || op == 9);
        e.c.branch     = (op == 12);
        e.c.call       = (op == 13);
        e.c.pc_to_mem  = (op == 13);
        e.c.ret        = (op == 14);
        return e;
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] a);
        return (wb_we && wb_addr == a) ? wb_data : regs[a];
    endfunction

    // ---------------- monitor ----------------
    exp_t e;
    logic hz, prev_hz = 0, held;

    initial begin
        forever begin
            @(negedge clk);
            if (!sb_on) prev_hz = 0;
            else begin
                held = (q.size() > 0);
                hz = 0;
                if (held) begin
                    e  = q[0];
                    hz = ex_memread && ((e.re0 && ex_dst == e.a0) || (e.re1 && ex_dst == e.a1));
                end
                chk("sb_id_valid", id_valid, held && !hz);
                chk("sb_if_ready", if_ready, !hz && !prev_hz && (!held || ex_ready));
                if (!id_valid) chk("sb_ctrl_idle", ctrl, 0);
                if (held && id_valid && ex_ready) begin
                    chk("sb_ctrl",   ctrl,      e.c);
                    chk("sb_rs",     rs,        e.ins[7:4]);
                    chk("sb_rt",     rt,        e.ins[3:0]);
                    chk("sb_rd",     rd,        e.ins[11:8]);
                    chk("sb_bcond",  bcond,     e.ins[11:9]);
                    chk("sb_dst",    id_dst,    e.dst);
                    chk("sb_imm",    imm,       e.imm);
                    chk("sb_offset", offset,    e.off);
                    chk("sb_pc",     id_pc_inc, e.pc);
                    chk("sb_pccall", pc_call,   e.pcc);
                    chk("sb_r0",     r0data,    m_read(e.a0));
                    chk("sb_r1",     r1data,    m_read(e.a1));
                    void'(q.pop_front());
                end
                prev_hz = hz;
            end
        end
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL timeout: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    logic acc;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_if_ready", if_ready, 1);
        chk("rst_halted", halted, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_pc", id_pc_inc, 0);

        cyc(); rst = 1; wb_we = 1; wb_addr = 3; wb_data = 16'h1234;
        cyc(); wb_addr = 15; wb_data = 16'h5555;
        cyc(); wb_we = 0; if_valid = 1; if_instr = 16'h0133; if_pc_inc = 16'h0011;
        cyc(); if_valid = 0;
        @(negedge clk);
        chk("add_valid", id_valid, 1);
        chk("add_r0", r0data, 16'h1234);
        chk("add_r1", r1data, 16'h1234);
        chk("add_regwrite", ctrl.reg_write, 1);
        chk("add_rd", rd, 1);
        chk("add_pc", id_pc_inc, 16'h0011);

        // back-pressure: outputs frozen while EX refuses
        cyc(); if_valid = 1; if_instr = 16'hB2F0; if_pc_inc = 16'h0022;
        cyc(); ex_ready = 0; if_instr = 16'h0000; if_pc_inc = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", id_valid, 1);
            chk("hold_if_ready", if_ready, 0);
            chk("hold_imm", imm, 16'hFFF0);
            chk("hold_rd", rd, 2);
            chk("hold_pc", id_pc_inc, 16'h0022);
            chk("hold_aluop", ctrl.alu_op, 4'hB);
        end
        cyc(); ex_ready = 1; if_valid = 0;

        // load-use stall
        cyc(); if_valid = 1; if_instr = 16'h1234; if_pc_inc = 16'h0030;
        cyc(); if_valid = 0; ex_memread = 1; ex_dst = 3;
        @(negedge clk);
        chk("hz_valid", id_valid, 0);
        chk("hz_if_ready", if_ready, 0);
        chk("hz_ctrl", ctrl, 0);
        cyc(); ex_memread = 0;
        @(negedge clk);
        chk("hz_release_valid", id_valid, 1);
        chk("hz_rs", rs, 3);
        chk("hz_rt", rt, 4);
        chk("hz_rd", rd, 2);
        chk("hz_aluop", ctrl.alu_op, 1);

        // write-port bypass
        cyc(); if_valid = 1; if_instr = 16'h3150; if_pc_inc = 16'h0040;
        cyc(); if_valid = 0; wb_we = 1; wb_addr = 5; wb_data = 16'hBEEF;
        @(negedge clk);
        chk("byp_r0", r0data, 16'hBEEF);
        chk("byp_r1", r1data, 16'h0000);

        // CALL
        cyc(); wb_we = 0; if_valid = 1; if_instr = 16'hD123; if_pc_inc = 16'h4001;
        cyc(); if_valid = 0;
        @(negedge clk);
        chk("call_pccall", pc_call, 16'h4123);
        chk("call_r0", r0data, 16'h5555);
        chk("call_dst", id_dst, 15);
        chk("call_ctrl", ctrl.call, 1);

        // flush beats a simultaneous load
        cyc(); if_valid = 1; if_instr = 16'h0133; if_pc_inc = 16'h0050;
        cyc(); flush = 1; if_instr = 16'h3150;
        cyc(); flush = 0; if_valid = 0;
        @(negedge clk);
        chk("flush_valid", id_valid, 0);
        chk("flush_if_ready", if_ready, 1);

        // flush on a held HLT prevents halting
        cyc(); if_valid = 1; if_instr = 16'hF000; if_pc_inc = 16'h0060; ex_ready = 0;
        cyc(); if_valid = 0; flush = 1; ex_ready = 1;
        cyc(); flush = 0;
        @(negedge clk);
        chk("hltflush_halted", halted, 0);
        chk("hltflush_if_ready", if_ready, 1);

        // HLT retires, then sticky
        cyc(); if_valid = 1; if_instr = 16'hF000;
        cyc(); if_instr = 16'h0133;
        @(negedge clk);
        chk("hlt_presented", id_valid, 1);
        chk("hlt_not_yet", halted, 0);
        cyc(); wb_we = 1; wb_addr = 7; wb_data = 16'h7777;
        repeat (3) begin
            @(negedge clk);
            chk("halt_halted", halted, 1);
            chk("halt_if_ready", if_ready, 0);
            chk("halt_valid", id_valid, 0);
        end
        #2 rst = 0;
        #1;
        chk("rst_async_halted", halted, 0);
        chk("rst_async_if_ready", if_ready, 1);
        cyc(); rst = 1; wb_we = 0; if_valid = 1; if_instr = 16'h0133; if_pc_inc = 16'h0070;
        #1;
        chk("post_rst_if_ready", if_ready, 1);
        cyc(); if_valid = 0;
        @(negedge clk);
        chk("post_rst_valid", id_valid, 1);
        chk("post_rst_r0_cleared", r0data, 0);

        // random traffic against the scoreboard
        cyc(); rst = 0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        q.delete();
        cyc(); rst = 1;
        acc = 0;
        sb_on = 1;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            if (wb_we) regs[wb_addr] = wb_data;
            if (acc) q.push_back(mk_exp(if_instr, if_pc_inc));
            #1;
            if_valid   = ($urandom_range(0, 9) < 7);
            if_instr   = {4'($urandom_range(0, 14)), 12'($urandom)};
            if_pc_inc  = 16'($urandom);
            ex_ready   = ($urandom_range(0, 3) != 0);
            ex_memread = ($urandom_range(0, 9) < 3);
            ex_dst     = 4'($urandom);
            wb_we      = ($urandom_range(0, 9) < 4);
            wb_addr    = 4'($urandom);
            wb_data    = 16'($urandom);
            @(negedge clk);
            acc = if_valid && if_ready;
        end
        @(posedge clk);
        if (wb_we) regs[wb_addr] = wb_data;
        if (acc) q.push_back(mk_exp(if_instr, if_pc_inc));
        #1;
        if_valid = 0; ex_ready = 1; ex_memread = 0; wb_we = 0;
        repeat (4) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        sb_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
